// File: rtl/ps2_cmd_pkg.sv
// Purpose : shared command bytes, FSM states, fail codes and script helpers
//           for the PS/2 mouse runtime configuration sequencer.
// Latency : n/a (types and pure functions only).
// Backpres: n/a.
package ps2_cmd_pkg;

  // PS/2 mouse command and response bytes
  localparam logic [7:0] CMD_FF = 8'hFF;  // idle value on the transmit bus
  localparam logic [7:0] CMD_F4 = 8'hF4;  // enable data reporting
  localparam logic [7:0] CMD_F5 = 8'hF5;  // disable data reporting
  localparam logic [7:0] CMD_F3 = 8'hF3;  // set sample rate
  localparam logic [7:0] CMD_E8 = 8'hE8;  // set resolution
  localparam logic [7:0] CMD_FA = 8'hFA;  // acknowledge
  localparam logic [7:0] CMD_FE = 8'hFE;  // resend request
  localparam logic [7:0] CMD_FC = 8'hFC;  // error

  localparam logic [2:0] LAST_STEP = 3'd5;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_RETRY    = 2'b01;
  localparam logic [1:0] FC_NAK      = 2'b10;
  localparam logic [1:0] FC_BAD_RATE = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_SENT,
    ST_WAIT_ACK,
    ST_RETRY,
    ST_NEXT,
    ST_DONE,
    ST_FAIL
  } state_t;

  // Sample rates the mouse accepts after an F3 command
  function automatic logic rate_is_legal(input logic [7:0] rate);
    case (rate)
      8'd10, 8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd200: rate_is_legal = 1'b1;
      default:                                           rate_is_legal = 1'b0;
    endcase
  endfunction

  // Byte transmitted at each script step
  function automatic logic [7:0] script_byte(input logic [2:0] step,
                                             input logic [7:0] rate,
                                             input logic [1:0] res);
    case (step)
      3'd0:    script_byte = CMD_F5;
      3'd1:    script_byte = CMD_F3;
      3'd2:    script_byte = rate;
      3'd3:    script_byte = CMD_E8;
      3'd4:    script_byte = {6'b0, res};
      default: script_byte = CMD_F4;
    endcase
  endfunction

endpackage

// File: rtl/ps2_cmd_sequencer_if.sv
// Purpose : transmitter/receiver handshake shared with the mouse master.
//           master = sequencer side, slave = PHY (transmitter/receiver) side.
// Latency : n/a. Backpres: the sequencer waits on BYTE_SENT / BYTE_READY.
// Signals : SEND_BYTE/BYTE_TO_SEND/BYTE_SENT (tx), READ_ENABLE/BYTE_READ/
//           BYTE_ERROR_CODE/BYTE_READY (rx).
interface ps2_cmd_sequencer_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  modport master (
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );

  modport slave (
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );
endinterface

// File: rtl/ps2_ack_timer.sv
// Purpose : saturating 24-bit cycle counter for the BYTE_SENT / ACK timeout.
// Latency : o_expired rises ACK_TIMEOUT enabled cycles after i_clr.
// Backpres: none; holds at ACK_TIMEOUT until cleared.
// Ports   : CLK, RESET (sync, high), i_clr, i_en, o_expired.
module ps2_ack_timer #(
  parameter int ACK_TIMEOUT = 750000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [23:0] LIMIT = 24'(ACK_TIMEOUT);

  logic [23:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RESET || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 24'd1;
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Purpose : runs the F5 / F3 rate / E8 res / F4 mouse setup script with
//           FE resend, FC/receiver-error abort, timeout retry; DONE or FAIL.
// Latency : first SEND_BYTE 3 cycles after START; illegal rate FAILs in 2.
// Backpres: waits on BYTE_SENT then an ACK byte; START ignored while BUSY.
// Ports   : CLK, RESET (sync, high), START, CFG_RATE, CFG_RES, io_ps2 (master),
//           BUSY, DONE, FAIL, FAIL_CODE, STEP.
module ps2_cmd_sequencer
  import ps2_cmd_pkg::*;
#(
  parameter int ACK_TIMEOUT = 750000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic [7:0]          CFG_RATE,
  input  logic [1:0]          CFG_RES,
  ps2_cmd_sequencer_if.master io_ps2,
  output logic                BUSY,
  output logic                DONE,
  output logic                FAIL,
  output logic [1:0]          FAIL_CODE,
  output logic [2:0]          STEP
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  state_t        r_state;
  logic [2:0]    r_step;
  logic [RW-1:0] r_retry;
  logic [7:0]    r_rate;
  logic [1:0]    r_res;
  logic          r_send;
  logic [7:0]    r_byte;
  logic          r_rd_en;
  logic          r_busy;
  logic          r_done;
  logic          r_fail;
  logic [1:0]    r_fail_code;

  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_expired;

  // Timer restarts on each transmission and again once the byte is on the
  // wire, so the ACK wait gets its own full window.
  assign w_tmr_clr = (r_state == ST_SEND) ||
                     ((r_state == ST_WAIT_SENT) && io_ps2.BYTE_SENT);
  assign w_tmr_en  = (r_state == ST_WAIT_SENT) || (r_state == ST_WAIT_ACK);

  ps2_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_step      <= '0;
      r_retry     <= '0;
      r_rate      <= '0;
      r_res       <= '0;
      r_send      <= 1'b0;
      r_byte      <= CMD_FF;
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_code <= FC_NONE;
    end else begin
      r_send <= 1'b0;
      r_done <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_rate      <= CFG_RATE;
            r_res       <= CFG_RES;
            r_fail_code <= FC_NONE;
            r_step      <= '0;
            r_retry     <= '0;
            r_busy      <= 1'b1;
            if (!rate_is_legal(CFG_RATE)) begin
              r_fail_code <= FC_BAD_RATE;
              r_state     <= ST_FAIL;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          r_byte  <= script_byte(r_step, r_rate, r_res);
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          r_send  <= 1'b1;
          r_state <= ST_WAIT_SENT;
        end
        ST_WAIT_SENT: begin
          if (io_ps2.BYTE_SENT) begin
            r_rd_en <= 1'b1;
            r_state <= ST_WAIT_ACK;
          end else if (w_expired) begin
            r_state <= ST_RETRY;
          end
        end
        ST_WAIT_ACK: begin
          // Receiver error outranks everything; a received byte outranks timeout.
          if (io_ps2.BYTE_ERROR_CODE != 2'b00) begin
            r_rd_en     <= 1'b0;
            r_fail_code <= FC_NAK;
            r_state     <= ST_FAIL;
          end else if (io_ps2.BYTE_READY) begin
            r_rd_en <= 1'b0;
            case (io_ps2.BYTE_READ)
              CMD_FA: r_state <= ST_NEXT;
              CMD_FE: r_state <= ST_RETRY;
              CMD_FC: begin
                r_fail_code <= FC_NAK;
                r_state     <= ST_FAIL;
              end
              default: begin
                r_fail_code <= FC_NAK;
                r_state     <= ST_FAIL;
              end
            endcase
          end else if (w_expired) begin
            r_rd_en <= 1'b0;
            r_state <= ST_RETRY;
          end
        end
        ST_RETRY: begin
          if (r_retry == RETRY_LIMIT) begin
            r_fail_code <= FC_RETRY;
            r_state     <= ST_FAIL;
          end else begin
            r_retry <= r_retry + 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_NEXT: begin
          r_retry <= '0;
          if (r_step == LAST_STEP) begin
            r_state <= ST_DONE;
          end else begin
            r_step  <= r_step + 3'd1;
            r_state <= ST_LOAD;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_FAIL: begin
          r_fail  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_ps2.SEND_BYTE    = r_send;
  assign io_ps2.BYTE_TO_SEND = r_byte;
  assign io_ps2.READ_ENABLE  = r_rd_en;
  assign BUSY                = r_busy;
  assign DONE                = r_done;
  assign FAIL                = r_fail;
  assign FAIL_CODE           = r_fail_code;
  assign STEP                = r_step;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Purpose : randomized scoreboard bench for ps2_cmd_sequencer with a
//           transmitter/mouse responder and a script-level reference model.
// Latency : n/a. Backpres: responder paces BYTE_SENT / reply bytes randomly.
module tb_ps2_cmd_sequencer;

  localparam int TMO  = 60;
  localparam int MAXR = 3;

  localparam int R_ACK    = 0;
  localparam int R_FE     = 1;
  localparam int R_FC     = 2;
  localparam int R_ERR    = 3;
  localparam int R_NOSENT = 4;
  localparam int R_NOACK  = 5;
  localparam int R_OTHER  = 6;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [7:0] CFG_RATE = 8'd0;
  logic [1:0] CFG_RES = 2'd0;
  logic       BUSY;
  logic       DONE;
  logic       FAIL;
  logic [1:0] FAIL_CODE;
  logic [2:0] STEP;

  ps2_cmd_sequencer_if bus();

  ps2_cmd_sequencer #(
    .ACK_TIMEOUT (TMO),
    .MAX_RETRY   (MAXR)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .CFG_RATE  (CFG_RATE),
    .CFG_RES   (CFG_RES),
    .io_ps2    (bus.master),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .FAIL      (FAIL),
    .FAIL_CODE (FAIL_CODE),
    .STEP      (STEP)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  int         legal_rates[7] = '{10, 20, 40, 60, 80, 100, 200};
  logic [7:0] exp_bytes[$];
  logic [2:0] exp_steps[$];
  int         resp_q[$];
  logic [3:0] exp_out[$];   // {done, fail, fail_code}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_send_byte"},    32'(bus.SEND_BYTE),    32'h0);
    check({tag, "_byte_to_send"}, 32'(bus.BYTE_TO_SEND), 32'hFF);
    check({tag, "_read_enable"},  32'(bus.READ_ENABLE),  32'h0);
    check({tag, "_busy"},         32'(BUSY),             32'h0);
    check({tag, "_done"},         32'(DONE),             32'h0);
    check({tag, "_fail"},         32'(FAIL),             32'h0);
    check({tag, "_fail_code"},    32'(FAIL_CODE),        32'h0);
    check({tag, "_step"},         32'(STEP),             32'h0);
  endtask

  function automatic logic [7:0] reply_byte(input int r);
    case (r)
      R_ACK:   return 8'hFA;
      R_FE:    return 8'hFE;
      R_FC:    return 8'hFC;
      default: return 8'hAA;
    endcase
  endfunction

  // Mouse behaviour for one transmission attempt
  function automatic int pick(input int mode, input int step, input int attempt);
    int u;
    case (mode)
      1: return (step == 2 && attempt == 0) ? R_FE : R_ACK;
      2: return (step == 1) ? R_FE : R_ACK;
      3: return (step == 3) ? R_FC : R_ACK;
      4: return (step == 0) ? R_ERR : R_ACK;
      5: begin
        u = int'($urandom_range(0, 99));
        if (u < 70) return R_ACK;
        if (u < 84) return R_FE;
        if (u < 88) return R_NOSENT;
        if (u < 92) return R_NOACK;
        if (u < 95) return R_FC;
        if (u < 98) return R_ERR;
        return R_OTHER;
      end
      6: return (step == 0 && attempt == 0) ? R_NOACK : R_ACK;
      7: return (step == 1 && attempt == 0) ? R_NOSENT : R_ACK;
      default: return R_ACK;
    endcase
  endfunction

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        if (bus.SEND_BYTE) begin
          if (exp_bytes.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_send: byte %0h sent, none expected (t=%0t)", bus.BYTE_TO_SEND, $time);
          end else begin
            check("sent_byte", 32'(bus.BYTE_TO_SEND), 32'(exp_bytes.pop_front()));
            check("step_at_send", 32'(STEP), 32'(exp_steps.pop_front()));
            check("busy_at_send", 32'(BUSY), 32'h1);
          end
        end
        if (DONE || FAIL) begin
          n_out++;
          if (exp_out.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_outcome: done=%0b fail=%0b code=%0b (t=%0t)", DONE, FAIL, FAIL_CODE, $time);
          end else begin
            check("outcome", 32'({DONE, FAIL, FAIL_CODE}), 32'(exp_out.pop_front()));
            check("busy_at_end", 32'(BUSY), 32'h0);
          end
        end
      end
    end
  end

  // Transmitter + mouse responder
  initial begin
    bus.BYTE_SENT       = 1'b0;
    bus.BYTE_READY      = 1'b0;
    bus.BYTE_READ       = 8'h00;
    bus.BYTE_ERROR_CODE = 2'b00;
    forever begin
      @(negedge CLK);
      if (bus.SEND_BYTE && !RESET && resp_q.size() > 0) begin
        int r;
        r = resp_q.pop_front();
        if (r != R_NOSENT) begin
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          bus.BYTE_SENT = 1'b1;
          @(negedge CLK);
          bus.BYTE_SENT = 1'b0;
          if (r != R_NOACK) begin
            repeat ($urandom_range(0, 4)) @(negedge CLK);
            if (r == R_ERR) begin
              bus.BYTE_ERROR_CODE = 2'b01;
            end else begin
              bus.BYTE_READY = 1'b1;
              bus.BYTE_READ  = reply_byte(r);
            end
            @(negedge CLK);
            bus.BYTE_READY      = 1'b0;
            bus.BYTE_ERROR_CODE = 2'b00;
            bus.BYTE_READ       = 8'h00;
          end
        end
      end
    end
  end

  task automatic run(input int mode, input logic [7:0] rate, input logic [1:0] res, input bit restart);
    logic [7:0] script[6];
    logic [3:0] outcome;
    int         step;
    int         retry;
    int         r;
    int         lat_exp;
    int         n0;
    bit         legal;
    bit         seen;

    // Reference model: walk the script and enqueue expectations
    legal = 1'b0;
    foreach (legal_rates[i]) if (legal_rates[i] == int'(rate)) legal = 1'b1;
    script = '{8'hF5, 8'hF3, rate, 8'hE8, {6'b0, res}, 8'hF4};
    step  = 0;
    retry = 0;
    if (!legal) begin
      outcome = 4'b0111;
    end else begin
      forever begin
        exp_bytes.push_back(script[step]);
        exp_steps.push_back(3'(step));
        r = pick(mode, step, retry);
        resp_q.push_back(r);
        if (r == R_FC || r == R_ERR || r == R_OTHER) begin
          outcome = 4'b0110;
          break;
        end
        if (r == R_ACK) begin
          retry = 0;
          if (step == 5) begin
            outcome = 4'b1000;
            break;
          end
          step++;
        end else begin
          if (retry == MAXR) begin
            outcome = 4'b0101;
            break;
          end
          retry++;
        end
      end
    end
    exp_out.push_back(outcome);
    lat_exp = legal ? 3 : 2;

    n0   = n_out;
    seen = 1'b0;
    @(negedge CLK);
    START    = 1'b1;
    CFG_RATE = rate;
    CFG_RES  = res;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge CLK);
      START = (restart && k == 12);
      if (restart && k == 12) CFG_RATE = 8'd50;
      if (!seen && (bus.SEND_BYTE || DONE || FAIL)) begin
        seen = 1'b1;
        check("first_event_latency", 32'(k), 32'(lat_exp));
      end
      if (n_out != n0) break;
    end
    if (n_out == n0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: mode %0d rate %0d produced no outcome", mode, rate);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      exp_bytes.delete();
      exp_steps.delete();
      resp_q.delete();
      exp_out.delete();
    end else begin
      repeat (3) @(negedge CLK);
      check("fail_code_held", 32'(FAIL_CODE), 32'(outcome[1:0]));
      check("bytes_drained", 32'(exp_bytes.size()), 32'h0);
      check("replies_drained", 32'(resp_q.size()), 32'h0);
      check("busy_idle", 32'(BUSY), 32'h0);
    end
  endtask

  task automatic reset_mid_ack();
    int n0;
    bit hit;
    n0  = n_out;
    hit = 1'b0;
    exp_bytes.push_back(8'hF5);
    exp_steps.push_back(3'd0);
    exp_bytes.push_back(8'hF3);
    exp_steps.push_back(3'd1);
    resp_q.push_back(R_ACK);
    resp_q.push_back(R_NOACK);
    @(negedge CLK);
    START    = 1'b1;
    CFG_RATE = 8'd100;
    CFG_RES  = 2'd2;
    for (int k = 0; k < 500; k++) begin
      @(negedge CLK);
      START = 1'b0;
      if (exp_bytes.size() == 0 && bus.READ_ENABLE) begin
        hit = 1'b1;
        break;
      end
    end
    check("reached_wait_ack", 32'(hit), 32'h1);
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check_reset_state("mid_reset");
    repeat (TMO * 2) @(negedge CLK);
    check("no_outcome_after_reset", 32'(n_out - n0), 32'h0);
    check("idle_after_reset", 32'(BUSY), 32'h0);
    resp_q.delete();
  endtask

  initial begin
    logic [7:0] rate;
    repeat (3) @(negedge CLK);
    check_reset_state("reset");
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    run(0, 8'd100, 2'd2, 1'b0);  // clean script
    run(1, 8'd100, 2'd2, 1'b0);  // one resend of the rate byte
    run(2, 8'd100, 2'd2, 1'b0);  // F3 always NAKed: retries exhausted
    run(3, 8'd20,  2'd1, 1'b0);  // FC after E8
    run(4, 8'd10,  2'd3, 1'b0);  // receiver error on first byte
    run(0, 8'd50,  2'd0, 1'b0);  // illegal rate
    run(6, 8'd200, 2'd0, 1'b1);  // ACK timeout then FA, START re-pulsed
    run(7, 8'd40,  2'd1, 1'b0);  // BYTE_SENT timeout
    reset_mid_ack();

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) != 0) rate = 8'(legal_rates[$urandom_range(0, 6)]);
      else rate = 8'($urandom_range(0, 255));
      run(5, rate, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ps2_cmd_sequencer.md
Name: ps2_cmd_sequencer

Overview:
- Runtime configuration controller for the PS/2 mouse link.
- Sits beside the mouse master state machine and drives the same transmitter/receiver handshake (send/sent, read-enable/ready/error) after the owner has handed over the link.
- On START it runs a fixed command script: disable reporting, set sample rate, set resolution, enable reporting.
- Handles ACK, resend (FE) and error (FC) responses with bounded retries and a timeout, and reports DONE or FAIL.

Parameters:
- ACK_TIMEOUT, 750000, cycles allowed for BYTE_SENT or the ACK byte before a retry (15 ms at 50 MHz); counter width 24 bits.
- MAX_RETRY, 3, resends allowed per script byte before failing.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- START  in  1  one-cycle request to run the script; ignored while BUSY
- CFG_RATE  in  8  sample rate value, sampled on accepted START
- CFG_RES  in  2  resolution code, sampled on accepted START
- SEND_BYTE  out  1  one-cycle transmit strobe
- BYTE_TO_SEND  out  8  byte presented to the transmitter
- BYTE_SENT  in  1  transmitter completion pulse
- READ_ENABLE  out  1  receiver enable
- BYTE_READ  in  8  received byte
- BYTE_ERROR_CODE  in  2  receiver error, non-zero means error
- BYTE_READY  in  1  received byte valid pulse
- BUSY  out  1  script in progress
- DONE  out  1  one-cycle success pulse
- FAIL  out  1  one-cycle failure pulse
- FAIL_CODE  out  2  01 retries exhausted, 10 FC or receiver error, 11 illegal CFG_RATE; held until the next accepted START
- STEP  out  3  index of the current script byte, for debug

Behaviour:
- Reset state:
  - All outputs 0, BYTE_TO_SEND = 8'hFF.
  - FSM in IDLE; step, retry count and timer cleared.
- Reset mid-script aborts immediately. No DONE or FAIL is emitted.
- Script bytes, steps 0..5: F5, F3, CFG_RATE latched, E8, {6'b0, CFG_RES latched}, F4.
- Legal CFG_RATE values: 10, 20, 40, 60, 80, 100, 200 (decimal).
- All outputs are registered.
- IDLE:
  - On START, latch the config and clear FAIL_CODE, step and retry count.
  - If the rate is illegal, go to FAIL with code 11; the bus is never driven.
  - Otherwise go to LOAD.
- LOAD: drive BYTE_TO_SEND from the step table; go to SEND.
- SEND:
  - SEND_BYTE = 1 for exactly one cycle; clear the timer; go to WAIT_SENT.
  - First SEND_BYTE appears 3 cycles after START.
- WAIT_SENT:
  - On BYTE_SENT, clear the timer and go to WAIT_ACK.
  - On timer == ACK_TIMEOUT, go to RETRY.
- WAIT_ACK: READ_ENABLE = 1. Priority, highest first:
  - BYTE_ERROR_CODE != 0 → FAIL, code 10.
  - BYTE_READY with FA → NEXT.
  - BYTE_READY with FE → RETRY.
  - BYTE_READY with FC or any other byte → FAIL, code 10.
  - Timer == ACK_TIMEOUT → RETRY.
  - BYTE_READY in the same cycle as the timeout: BYTE_READY wins.
- RETRY: if retry count == MAX_RETRY, go to FAIL with code 01; else increment the count and go to LOAD, resending the same byte.
- NEXT: clear the retry count; if step == 5 go to DONE, else increment step and go to LOAD.
- DONE: DONE = 1 for one cycle; go to IDLE.
- FAIL: FAIL = 1 for one cycle; go to IDLE.
- BUSY = 1 in every state except IDLE. It falls in the same cycle DONE or FAIL rises.
- BYTE_SENT and BYTE_READY are ignored outside their wait states.
- Timer saturates, no wrap. Retry counter width is clog2(MAX_RETRY+1).

Decomposition:
- Package ps2_cmd_pkg:
  - command constants: FF, F4, F5, F3, E8, FA, FE, FC
  - FSM state enum: IDLE, LOAD, SEND, WAIT_SENT, WAIT_ACK, RETRY, NEXT, DONE, FAIL
  - FAIL_CODE constants
  - legal-rate check function
- Sub-module ps2_ack_timer:
  - inputs: clear, enable
  - output: expired, at ACK_TIMEOUT
  - saturating

Test Plan:
- START with rate 100 and res 2; a transmitter model pulses BYTE_SENT and the mouse returns FA to every byte → bytes F5, F3, 64, E8, 02, F4 in order; one DONE pulse; FAIL_CODE = 00.
- FE returned once for byte 64 → 64 is re-sent exactly once; script completes with DONE.
- FE returned on every F3 with MAX_RETRY = 3 → F3 sent 4 times; FAIL pulse with code 01; no E8 ever sent.
- FC returned after E8, or BYTE_ERROR_CODE = 01 in WAIT_ACK → FAIL pulse with code 10 on the next cycle.
- START with CFG_RATE = 50 → no SEND_BYTE; FAIL pulse with code 11 two cycles after START.
- No ACK for ACK_TIMEOUT cycles, then FA; START re-pulsed mid-script; RESET asserted mid-WAIT_ACK → retry on timeout, second START ignored, reset returns all outputs to reset values with no DONE or FAIL.
